// File: rtl/stack_pointer_unit.sv
// stack_pointer_unit
// Stack pointer register S plus a push/pop sequencer that issues page-one
// stack accesses {STACK_PAGE, S} for multi-byte pushes (post-decrement) and
// pops (pre-increment), using a req/ack handshake toward memory.
//
// Ports:
//   phi_2, rst              clock, synchronous active-high reset
//   sb_s, sb_in             load S from the SB bus (IDLE only)
//   s_sb, s_adl             drive S onto sb_bus / adl_bus (else high-Z)
//   sb_bus, adl_bus         tri-state bus drives
//   s_value                 current S
//   cmd_valid/cmd_ready     command handshake; cmd_pop, cmd_len (0 means 1)
//   cmd_done                one-cycle pulse when a command completes
//   byte_idx                index of the current byte within the command
//   push_data               write data, sampled on the acknowledged write
//   pop_data, pop_valid     last popped byte and its update pulse
//   mem_req/we/addr/wdata   stack access request toward memory
//   mem_rdata, mem_ack      memory response
module stack_pointer_unit #(
  parameter logic [7:0] RESET_S    = 8'hFD,
  parameter logic [7:0] STACK_PAGE = 8'h01
) (
  input  logic        phi_2,
  input  logic        rst,
  input  logic        sb_s,
  input  logic [7:0]  sb_in,
  input  logic        s_sb,
  input  logic        s_adl,
  output wire  [7:0]  sb_bus,
  output wire  [7:0]  adl_bus,
  output logic [7:0]  s_value,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_pop,
  input  logic [1:0]  cmd_len,
  output logic        cmd_done,
  output logic [1:0]  byte_idx,
  input  logic [7:0]  push_data,
  output logic [7:0]  pop_data,
  output logic        pop_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PUSH    = 2'd1,
    POP_INC = 2'd2,
    POP_RD  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   s_q, s_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic [LEN_W-1:0]    byte_idx_q, byte_idx_d;
  logic [DATA_W-1:0]   pop_data_q, pop_data_d;
  logic                pop_valid_q, pop_valid_d;
  logic                cmd_done_q, cmd_done_d;

  // State register
  always_ff @(posedge phi_2) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= RESET_S;
      remaining_q <= '0;
      byte_idx_q  <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      cmd_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      remaining_q <= remaining_d;
      byte_idx_q  <= byte_idx_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      cmd_done_q  <= cmd_done_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    remaining_d = remaining_q;
    byte_idx_d  = byte_idx_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    cmd_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // A bus load of S wins over a command presented in the same cycle
        if (sb_s) begin
          s_d = sb_in;
        end else if (cmd_valid) begin
          remaining_d = (cmd_len == LEN_W'(0)) ? LEN_W'(1) : cmd_len;
          byte_idx_d  = '0;
          state_d     = cmd_pop ? POP_INC : PUSH;
        end
      end
      PUSH: begin
        if (mem_ack) begin
          s_d         = s_q - DATA_W'(1);
          byte_idx_d  = byte_idx_q + LEN_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d    = IDLE;
            cmd_done_d = 1'b1;
          end
        end
      end
      POP_INC: begin
        s_d     = s_q + DATA_W'(1);
        state_d = POP_RD;
      end
      POP_RD: begin
        if (mem_ack) begin
          pop_data_d  = mem_rdata;
          pop_valid_d = 1'b1;
          byte_idx_d  = byte_idx_q + LEN_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d    = IDLE;
            cmd_done_d = 1'b1;
          end else begin
            state_d = POP_INC;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    cmd_ready = 1'b0;
    case (state_q)
      IDLE:   cmd_ready = !sb_s;
      PUSH: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = push_data;
      end
      POP_RD: mem_req = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr  = {STACK_PAGE, s_q};
  assign s_value   = s_q;
  assign byte_idx  = byte_idx_q;
  assign pop_data  = pop_data_q;
  assign pop_valid = pop_valid_q;
  assign cmd_done  = cmd_done_q;

  // Tri-state bus drivers
  assign sb_bus  = s_sb  ? s_q : 8'hzz;
  assign adl_bus = s_adl ? s_q : 8'hzz;

endmodule

// File: doc/stack_pointer_unit.md
# stack_pointer_unit

Stack pointer register (S) with a push/pop sequencer that generates page-one stack accesses, {8'h01, S}, for multi-byte pushes (JSR/BRK/IRQ) and pops (RTS/RTI). The program counter counts up and feeds fetch addresses; this block is the complementary down/up counter on the ADL/SB side. It loads from and drives the internal buses, and initiates a request/acknowledge handshake toward the memory interface.

## Interface
- Parameters:
- RESET_S, 8'hFD, value loaded into S on reset.
- STACK_PAGE, 8'h01, constant high address byte for every stack access.
- Ports (all control inputs active-high):
- phi_2  input  1  clock, all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- sb_s  input  1  load S from sb_in (IDLE only).
- sb_in  input  8  SB bus value for loading S.
- s_sb  input  1  drive S onto sb_bus; otherwise sb_bus is 8'hzz.
- s_adl  input  1  drive S onto adl_bus; otherwise adl_bus is 8'hzz.
- sb_bus  output  8  tri-state SB drive.
- adl_bus  output  8  tri-state ADL drive.
- s_value  output  8  current S, always driven.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  block accepts a command this cycle.
- cmd_pop  input  1  0 = push, 1 = pop.
- cmd_len  input  2  byte count 1..3; 0 is treated as 1.
- cmd_done  output  1  one-cycle pulse when a command completes.
- byte_idx  output  2  index of the current byte within the command, starting at 0.
- push_data  input  8  byte to write; sampled when the write is acknowledged.
- pop_data  output  8  last popped byte (registered).
- pop_valid  output  1  one-cycle pulse when pop_data updates.
- mem_req  output  1  stack access request.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  output  16  {STACK_PAGE, S}.
- mem_wdata  output  8  equals push_data while a push is in progress.
- mem_rdata  input  8  read data; valid on the cycle mem_ack is high.
- mem_ack  input  1  access complete; sampled on rising edge while mem_req is high.

## Operation
- Reset (rst high on an edge, overrides everything):
  - S = RESET_S; state = IDLE; remaining = 0; byte_idx = 0.
  - pop_data = 8'h00.
  - mem_req, pop_valid and cmd_done are all 0.
  - cmd_ready = 1 from the first cycle after reset.
  - Reset mid-command aborts the command; no cmd_done is issued.
- States: IDLE, PUSH, POP_INC, POP_RD.
- IDLE:
  - cmd_ready = !sb_s.
  - If sb_s is high, S <= sb_in and any command is not accepted that cycle.
  - Otherwise, if cmd_valid is high: latch direction and remaining = (cmd_len==0 ? 1 : cmd_len), set byte_idx = 0, then go to PUSH (push) or POP_INC (pop).
- PUSH:
  - Outputs: mem_req = 1, mem_we = 1, mem_addr = {01, S}.
  - On mem_ack: S <= S - 1, byte_idx++, remaining--.
  - If remaining was 1, go to IDLE and pulse cmd_done.
- POP_INC:
  - mem_req = 0; S <= S + 1; go to POP_RD.
- POP_RD:
  - Outputs: mem_req = 1, mem_we = 0, mem_addr = {01, S}.
  - On mem_ack: pop_data <= mem_rdata, pulse pop_valid, byte_idx++, remaining--.
  - If remaining was 1, go to IDLE and pulse cmd_done; otherwise go to POP_INC.
- Without mem_ack, the state, S and mem_addr hold indefinitely.
- Arithmetic is modulo 256:
  - A push at S = 8'h00 writes 16'h0100, then S = 8'hFF.
  - A pop with S = 8'hFF reads 16'h0100 with S = 8'h00.
  - mem_addr[15:8] is always STACK_PAGE.
- sb_s outside IDLE is ignored; S is unchanged.
- s_sb and s_adl act in any state and reflect the registered S. Both may be asserted together.
- cmd_valid outside IDLE is ignored; there is no queuing.

## Timing
- Command acceptance occurs on the edge where cmd_valid && cmd_ready.
- mem_req is high starting the next cycle for a push, or two cycles later for a pop (POP_INC first).
- With a zero-wait memory (mem_ack high whenever mem_req is high):
  - A push of n bytes holds mem_req for n consecutive cycles.
  - A pop of n bytes takes 2n cycles, with mem_req alternating 0/1.
- cmd_done and pop_valid are registered and appear the cycle after the completing ack edge.
  - cmd_ready is high in that same cycle, so back-to-back commands lose no cycle.
- The S update is visible on s_value, sb_bus and adl_bus the cycle after the update edge.

## Test plan
- Reset, then idle:
  - s_value = 8'hFD, mem_req = 0, cmd_ready = 1, sb_bus and adl_bus = z.
- sb_in = 8'h42 with sb_s for one cycle, then s_adl:
  - adl_bus = 8'h42, s_value = 8'h42.
- S = 8'hFD, push len 2 with push_data 8'h12 then 8'h34, zero-wait:
  - Writes 16'h01FD = 12 then 16'h01FC = 34.
  - Final S = 8'hFB; cmd_done pulses once.
- S = 8'hFB, pop len 3, mem_rdata = 8'hA0/A1/A2:
  - Reads 16'h01FC, 01FD, 01FE.
  - pop_valid pulses three times with A0, A1, A2.
  - Final S = 8'hFE.
- Wrap-around, with 2-cycle ack wait on every access:
  - S = 8'h00, push len 1: writes 16'h0100, S = 8'hFF.
  - Then pop len 1: reads 16'h0100, S = 8'h00.
  - mem_addr stays stable through the wait cycles.
- Simultaneous and abort cases:
  - sb_s together with cmd_valid in IDLE: S loads and the command is not accepted.
  - rst asserted during the second byte of a push len 3: next cycle S = 8'hFD, mem_req = 0, no cmd_done.
